// File: rtl/can_rx_buffer_pkg.sv
// Shared field widths and entry layout for the CAN receive packet buffer.
package can_rx_buffer_pkg;

    localparam int unsigned IdW    = 29;
    localparam int unsigned LenW   = 4;
    localparam int unsigned DataW  = 64;
    localparam int unsigned EntryW = 98;

    localparam int unsigned DataLsb = 0;
    localparam int unsigned LenLsb  = 64;
    localparam int unsigned IdeBit  = 68;
    localparam int unsigned IdLsb   = 69;

    // Packed MSB-first: id [97:69], ide [68], len [67:64], data [63:0].
    typedef struct packed {
        logic [IdW-1:0]   id;
        logic             ide;
        logic [LenW-1:0]  len;
        logic [DataW-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/can_pkt_fifo.sv
// Synchronous packet FIFO with first-word-fall-through head; head reads 0 while empty.
module can_pkt_fifo
    import can_rx_buffer_pkg::*;
#(
    parameter int unsigned ASIZE = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push_i,
    input  logic [EntryW-1:0] wdata_i,
    input  logic              pop_i,
    output logic [EntryW-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ASIZE:0]    level_o
);

    localparam int unsigned Depth = 1 << ASIZE;

    logic [ASIZE:0]    wptr_q, wptr_d;
    logic [ASIZE:0]    rptr_q, rptr_d;
    logic [EntryW-1:0] mem_q [Depth];
    logic              do_push, do_pop;

    always_comb begin
        full_o  = (wptr_q == {~rptr_q[ASIZE], rptr_q[ASIZE-1:0]});
        empty_o = (wptr_q == rptr_q);
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        level_o = wptr_q - rptr_q;
        rdata_o = empty_o ? '0 : mem_q[rptr_q[ASIZE-1:0]];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[ASIZE-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/can_rx_buffer.sv
// Reassembles the unbuffered CAN RX byte stream into whole packets and queues them
// for the consumer; packets that overrun 8 bytes or meet a full FIFO are counted and dropped.
module can_rx_buffer
    import can_rx_buffer_pkg::*;
#(
    parameter int unsigned ASIZE = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [7:0]       in_data,
    input  logic [IdW-1:0]   in_id,
    input  logic             in_ide,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IdW-1:0]   out_id,
    output logic             out_ide,
    output logic [LenW-1:0]  out_len,
    output logic [DataW-1:0] out_data,
    output logic [ASIZE:0]   level,
    output logic             drop_pulse,
    output logic [7:0]       drop_cnt
);

    logic [DataW-1:0] sr_q, sr_d;
    logic [LenW-1:0]  cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic [IdW-1:0]   id_q, id_d;
    logic             ide_q, ide_d;
    logic             drop_pulse_q, drop_pulse_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic      push, fifo_full, fifo_empty;
    rx_entry_t wentry, rentry;

    always_comb begin
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        ovr_d        = ovr_q;
        id_d         = id_q;
        ide_d        = ide_q;
        push         = 1'b0;
        drop_pulse_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        wentry       = '0;
        if (in_valid) begin
            // cnt only returns to 0 at commit, so cnt==0 marks the first byte.
            if (cnt_q == '0) begin
                id_d  = in_id;
                ide_d = in_ide;
            end
            if (cnt_q < 4'd8) begin
                sr_d  = {sr_q[DataW-9:0], in_data};
                cnt_d = cnt_q + 4'd1;
            end else begin
                ovr_d = 1'b1;
            end
            if (in_last) begin
                wentry = '{id: id_d, ide: ide_d, len: cnt_d, data: sr_d};
                if (fifo_full || ovr_d) begin
                    drop_pulse_d = 1'b1;
                    if (drop_cnt_q != 8'hff) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end else begin
                    push = 1'b1;
                end
                sr_d  = '0;
                cnt_d = '0;
                ovr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr_q         <= '0;
            cnt_q        <= '0;
            ovr_q        <= 1'b0;
            id_q         <= '0;
            ide_q        <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            ovr_q        <= ovr_d;
            id_q         <= id_d;
            ide_q        <= ide_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    can_pkt_fifo #(
        .ASIZE (ASIZE)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (out_ready),
        .rdata_o (rentry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_comb begin
        out_valid  = ~fifo_empty;
        out_id     = rentry.id;
        out_ide    = rentry.ide;
        out_len    = rentry.len;
        out_data   = rentry.data;
        drop_pulse = drop_pulse_q;
        drop_cnt   = drop_cnt_q;
    end

endmodule

// File: tb/tb_can_rx_buffer.sv
// Randomized and directed bench for can_rx_buffer against a queue-based packet model.
module tb_can_rx_buffer;

    localparam int unsigned Depth = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_last, in_ide, out_ready;
    logic [7:0]  in_data;
    logic [28:0] in_id;
    logic        out_valid, out_ide, drop_pulse;
    logic [28:0] out_id;
    logic [3:0]  out_len;
    logic [63:0] out_data;
    logic [4:0]  level;
    logic [7:0]  drop_cnt;

    can_rx_buffer #(
        .ASIZE (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_data    (in_data),
        .in_id      (in_id),
        .in_ide     (in_ide),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_ide    (out_ide),
        .out_len    (out_len),
        .out_data   (out_data),
        .level      (level),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] id;
        logic        ide;
        int          len;
        logic [63:0] data;
    } pkt_t;

    pkt_t        mq[$];
    logic [7:0]  asm_b[$];
    logic [28:0] asm_id;
    logic        asm_ide;
    int          exp_drop;
    bit          exp_pulse;
    bit          rdy;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("level", 64'(level), 64'(mq.size()));
        check("drop_pulse", 64'(drop_pulse), 64'(exp_pulse));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        if (mq.size() != 0) begin
            check("out_id", 64'(out_id), 64'(mq[0].id));
            check("out_ide", 64'(out_ide), 64'(mq[0].ide));
            check("out_len", 64'(out_len), 64'(mq[0].len));
            check("out_data", out_data, mq[0].data);
        end else begin
            check("out_id_empty", 64'(out_id), 64'd0);
            check("out_len_empty", 64'(out_len), 64'd0);
            check("out_data_empty", out_data, 64'd0);
        end
    endtask

    // Packet-level model of one clock: full is judged before this cycle's pop.
    task automatic model_step(input bit v, input bit l, input logic [7:0] d,
                              input logic [28:0] id, input bit ide, input bit r);
        bit   full = (mq.size() == Depth);
        bit   pop = r && (mq.size() != 0);
        bit   store = 0;
        pkt_t p;
        exp_pulse = 0;
        if (v) begin
            if (asm_b.size() == 0) begin
                asm_id  = id;
                asm_ide = ide;
            end
            asm_b.push_back(d);
            if (l) begin
                if (asm_b.size() > 8 || full) begin
                    exp_pulse = 1;
                    if (exp_drop < 255) exp_drop++;
                end else begin
                    p.id   = asm_id;
                    p.ide  = asm_ide;
                    p.len  = asm_b.size();
                    p.data = '0;
                    foreach (asm_b[i]) p.data = (p.data << 8) | 64'(asm_b[i]);
                    store = 1;
                end
                asm_b.delete();
            end
        end
        if (pop) void'(mq.pop_front());
        if (store) mq.push_back(p);
    endtask

    task automatic cycle(input bit v, input bit l, input logic [7:0] d,
                         input logic [28:0] id, input bit ide);
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        in_id     = id;
        in_ide    = ide;
        out_ready = rdy;
        model_step(v, l, d, id, ide, rdy);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 29'd0, 0);
    endtask

    // bytes[7:0] is sent first.
    task automatic send_pkt(input int n, input logic [28:0] id, input bit ide,
                            input logic [95:0] bytes);
        for (int i = 0; i < n; i++) cycle(1, i == n - 1, bytes[8*i +: 8], id, ide);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        in_valid  = 0;
        in_last   = 0;
        in_data   = 0;
        in_id     = 0;
        in_ide    = 0;
        out_ready = 0;
        mq.delete();
        asm_b.delete();
        exp_drop  = 0;
        exp_pulse = 0;
        #1;
        check_outputs();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b1;
        rdy  = 0;
        do_reset();

        rdy = 1;
        send_pkt(3, 29'h123, 0, 96'h332211);
        idle(2);
        send_pkt(8, 29'h12345678, 1, 96'h0807060504030201);
        idle(2);
        send_pkt(2, 29'h0aa, 0, 96'hb2b1);
        send_pkt(5, 29'h1abcdef0, 1, 96'hc5c4c3c2c1);
        idle(3);

        rdy = 0;
        for (int i = 0; i < 17; i++) send_pkt(1, 29'(i + 1), i[0], 96'(8'h40 + i));
        idle(1);
        rdy = 1;
        idle(18);

        send_pkt(9, 29'h055, 0, 96'h090807060504030201);
        send_pkt(4, 29'h066, 0, 96'hd4d3d2d1);
        idle(2);

        rdy = 0;
        send_pkt(1, 29'h077, 0, 96'he1);
        cycle(1, 0, 8'hf1, 29'h088, 1);
        cycle(1, 0, 8'hf2, 29'h088, 1);
        cycle(1, 0, 8'hf3, 29'h088, 1);
        do_reset();
        rdy = 1;
        send_pkt(2, 29'h099, 0, 96'ha2a1);
        idle(2);

        for (int ph = 0; ph < 3; ph++) begin
            int bias = (ph == 0) ? 10 : (ph == 1) ? 50 : 90;
            for (int k = 0; k < 100; k++) begin
                int          n = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 11)
                                                             : $urandom_range(1, 8);
                bit          ide = 1'($urandom_range(0, 1));
                logic [28:0] id = ide ? 29'($urandom) : 29'($urandom_range(0, 2047));
                logic [95:0] b = {$urandom, $urandom, $urandom};
                for (int i = 0; i < n; i++) begin
                    rdy = ($urandom_range(0, 99) < bias);
                    cycle(1, i == n - 1, b[8*i +: 8], id, ide);
                end
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    rdy = ($urandom_range(0, 99) < bias);
                    cycle(0, 0, 8'(g), 29'd0, 0);
                end
            end
        end
        rdy = 1;
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
